// File: rtl/rename_pkg.sv
// Shared widths, index types and the renamed-instruction record for the rename stage.
// Types are sized for the default 32 arch / 64 phys / 4 checkpoint configuration.
package rename_pkg;

  localparam int DEF_ARCH_REGS = 32;
  localparam int DEF_PHYS_REGS = 64;
  localparam int DEF_CKPT      = 4;

  localparam int AREG_BITS = $clog2(DEF_ARCH_REGS);
  localparam int PREG_BITS = $clog2(DEF_PHYS_REGS);
  localparam int CKPT_BITS = $clog2(DEF_CKPT);

  typedef logic [AREG_BITS-1:0] areg_t;
  typedef logic [PREG_BITS-1:0] preg_t;
  typedef logic [CKPT_BITS-1:0] ckpt_id_t;

  typedef struct packed {
    preg_t    prs;
    preg_t    prt;
    preg_t    prd;
    preg_t    old_prd;
    logic     rs_rdy;
    logic     rt_rdy;
    logic     ckpt_valid;
    ckpt_id_t ckpt_id;
  } rename_out_t;

endpackage

// File: rtl/rename_free_list.sv
// Circular free list of physical registers; head can be rewound on mispredict recovery.
// Pop and push both take effect at the clock edge, so a pushed entry is poppable next cycle.
module rename_free_list #(
  parameter int NUM_ENTRIES = 64,
  parameter int INIT_BASE   = 32,
  parameter int PTR_W       = $clog2(NUM_ENTRIES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pop,
  input  logic             push,
  input  logic [PTR_W-1:0] push_dat,
  input  logic             restore,
  input  logic [PTR_W-1:0] restore_ptr,
  output logic [PTR_W-1:0] head_dat,
  output logic [PTR_W-1:0] head_ptr_nxt,
  output logic [PTR_W:0]   count
);

  localparam int INIT_CNT = NUM_ENTRIES - INIT_BASE;

  logic [PTR_W-1:0] mem [NUM_ENTRIES];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W-1:0] tail_nxt;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(NUM_ENTRIES - 1)) ? '0 : p + 1'b1;
  endfunction

  // Occupancy from pointers alone: head==tail means empty, since a full list would
  // imply no architectural register holds a mapping.
  function automatic logic [PTR_W:0] ptr_dist(input logic [PTR_W-1:0] t, input logic [PTR_W-1:0] h);
    if (t >= h) return {1'b0, t} - {1'b0, h};
    return {1'b0, t} + (PTR_W+1)'(NUM_ENTRIES) - {1'b0, h};
  endfunction

  assign head_dat     = mem[head];
  assign head_ptr_nxt = pop ? ptr_inc(head) : head;
  assign tail_nxt     = push ? ptr_inc(tail) : tail;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ENTRIES; i++)
        mem[i] <= (i < INIT_CNT) ? PTR_W'(INIT_BASE + i) : '0;
      head  <= '0;
      tail  <= PTR_W'(INIT_CNT);
      count <= (PTR_W+1)'(INIT_CNT);
    end else begin
      if (push) mem[tail] <= push_dat;
      tail <= tail_nxt;
      if (restore) begin
        head  <= restore_ptr;
        count <= ptr_dist(tail_nxt, restore_ptr);
      end else begin
        head  <= head_ptr_nxt;
        count <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
      end
    end
  end

  always @(posedge clk) begin
    if (rst_n) assert (!(push && count == (PTR_W+1)'(NUM_ENTRIES)));
  end

endmodule

// File: rtl/rename_unit_ckpt.sv
// Register rename stage: RMT + free list + busy table with branch checkpoints for one-cycle recovery.
// One-cycle latency into a held output register; stalls on downstream backpressure, empty free list or full checkpoints.
module rename_unit_ckpt
  import rename_pkg::*;
#(
  parameter int NUM_ARCH_REGS = DEF_ARCH_REGS,
  parameter int NUM_PHYS_REGS = DEF_PHYS_REGS,
  parameter int NUM_CKPT      = DEF_CKPT,
  parameter int AREG_W        = $clog2(NUM_ARCH_REGS),
  parameter int PREG_W        = $clog2(NUM_PHYS_REGS),
  parameter int CKPT_W        = $clog2(NUM_CKPT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_uses_rs,
  input  logic              in_uses_rt,
  input  logic              in_uses_rw,
  input  logic [AREG_W-1:0] in_rs,
  input  logic [AREG_W-1:0] in_rt,
  input  logic [AREG_W-1:0] in_rw,
  input  logic              in_is_branch,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PREG_W-1:0] out_prs,
  output logic [PREG_W-1:0] out_prt,
  output logic [PREG_W-1:0] out_prd,
  output logic [PREG_W-1:0] out_old_prd,
  output logic              out_rs_rdy,
  output logic              out_rt_rdy,
  output logic              out_ckpt_valid,
  output logic [CKPT_W-1:0] out_ckpt_id,
  input  logic              wb_valid,
  input  logic [PREG_W-1:0] wb_preg,
  input  logic              commit_valid,
  input  logic [PREG_W-1:0] commit_old_prd,
  input  logic              br_resolve_valid,
  input  logic              recover_valid,
  input  logic [CKPT_W-1:0] recover_id
);

  logic [PREG_W-1:0]    rmt      [NUM_ARCH_REGS];
  logic [PREG_W-1:0]    rmt_upd  [NUM_ARCH_REGS];
  logic [PREG_W-1:0]    ckpt_rmt [NUM_CKPT][NUM_ARCH_REGS];
  logic [PREG_W-1:0]    ckpt_fl_head [NUM_CKPT];
  logic [NUM_PHYS_REGS-1:0] busy;

  logic [CKPT_W-1:0] ck_head, ck_tail, ck_head_nxt;
  logic [CKPT_W:0]   ck_count;

  logic              fire, has_dst, alloc, fl_push, ck_push, ck_pop;
  logic [PREG_W-1:0] fl_head_dat, fl_head_ptr_nxt;
  logic [PREG_W:0]   fl_count;
  logic [PREG_W-1:0] prs, prt;
  logic              rs_rdy, rt_rdy;

  rename_out_t out_q;
  logic        out_valid_q;

  function automatic logic [CKPT_W-1:0] ck_inc(input logic [CKPT_W-1:0] p);
    return (p == CKPT_W'(NUM_CKPT - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [CKPT_W:0] ck_dist(input logic [CKPT_W-1:0] t, input logic [CKPT_W-1:0] h);
    if (t >= h) return {1'b0, t} - {1'b0, h};
    return {1'b0, t} + (CKPT_W+1)'(NUM_CKPT) - {1'b0, h};
  endfunction

  assign has_dst  = in_uses_rw && (in_rw != '0);
  assign in_ready = !recover_valid && (!out_valid_q || out_ready)
                  && !(has_dst && fl_count == '0)
                  && !(in_is_branch && ck_count == (CKPT_W+1)'(NUM_CKPT));
  assign fire     = in_valid && in_ready;
  assign alloc    = fire && has_dst;
  assign fl_push  = commit_valid && (commit_old_prd != '0);
  assign ck_push  = fire && in_is_branch;
  assign ck_pop   = br_resolve_valid && (ck_count != '0);
  assign ck_head_nxt = ck_pop ? ck_inc(ck_head) : ck_head;

  // Sources see the map before this instruction's own destination update.
  assign prs    = rmt[in_rs];
  assign prt    = rmt[in_rt];
  assign rs_rdy = !in_uses_rs || (in_rs == '0) || !busy[prs] || (wb_valid && wb_preg == prs);
  assign rt_rdy = !in_uses_rt || (in_rt == '0) || !busy[prt] || (wb_valid && wb_preg == prt);

  always_comb begin
    rmt_upd = rmt;
    if (alloc) rmt_upd[in_rw] = fl_head_dat;
  end

  rename_free_list #(
    .NUM_ENTRIES (NUM_PHYS_REGS),
    .INIT_BASE   (NUM_ARCH_REGS),
    .PTR_W       (PREG_W)
  ) u_free_list (
    .clk          (clk),
    .rst_n        (rst_n),
    .pop          (alloc),
    .push         (fl_push),
    .push_dat     (commit_old_prd),
    .restore      (recover_valid),
    .restore_ptr  (ckpt_fl_head[recover_id]),
    .head_dat     (fl_head_dat),
    .head_ptr_nxt (fl_head_ptr_nxt),
    .count        (fl_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ARCH_REGS; i++) rmt[i] <= PREG_W'(i);
    end else if (recover_valid) begin
      rmt <= ckpt_rmt[recover_id];
    end else begin
      rmt <= rmt_upd;
    end
  end

  // Writeback clear is issued first so a same-cycle allocation of that register wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      if (wb_valid) busy[wb_preg] <= 1'b0;
      if (alloc)    busy[fl_head_dat] <= 1'b1;
    end
  end

  // Snapshot storage is only meaningful between tail and head, so it needs no reset.
  always_ff @(posedge clk) begin
    if (ck_push) begin
      ckpt_rmt[ck_tail]     <= rmt_upd;
      ckpt_fl_head[ck_tail] <= fl_head_ptr_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ck_head  <= '0;
      ck_tail  <= '0;
      ck_count <= '0;
    end else begin
      ck_head <= ck_head_nxt;
      if (recover_valid) begin
        ck_tail  <= recover_id;
        ck_count <= ck_dist(recover_id, ck_head_nxt);
      end else begin
        if (ck_push) ck_tail <= ck_inc(ck_tail);
        ck_count <= ck_count + (CKPT_W+1)'(ck_push) - (CKPT_W+1)'(ck_pop);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else if (fire) begin
      out_valid_q        <= 1'b1;
      out_q.prs          <= prs;
      out_q.prt          <= prt;
      out_q.prd          <= alloc ? fl_head_dat : '0;
      out_q.old_prd      <= alloc ? rmt[in_rw] : '0;
      out_q.rs_rdy       <= rs_rdy;
      out_q.rt_rdy       <= rt_rdy;
      out_q.ckpt_valid   <= in_is_branch;
      out_q.ckpt_id      <= in_is_branch ? ck_tail : '0;
    end else if (out_ready || recover_valid) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid      = out_valid_q;
  assign out_prs        = out_q.prs;
  assign out_prt        = out_q.prt;
  assign out_prd        = out_q.prd;
  assign out_old_prd    = out_q.old_prd;
  assign out_rs_rdy     = out_q.rs_rdy;
  assign out_rt_rdy     = out_q.rt_rdy;
  assign out_ckpt_valid = out_q.ckpt_valid;
  assign out_ckpt_id    = out_q.ckpt_id;

endmodule

// File: tb/tb_rename_unit_ckpt.sv
// Directed bench for rename_unit_ckpt with hand-computed expectations.
module tb_rename_unit_ckpt;

  localparam int AW = 5;
  localparam int PW = 6;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid, in_ready, in_uses_rs, in_uses_rt, in_uses_rw, in_is_branch;
  logic [AW-1:0] in_rs, in_rt, in_rw;
  logic          out_valid, out_ready;
  logic [PW-1:0] out_prs, out_prt, out_prd, out_old_prd;
  logic          out_rs_rdy, out_rt_rdy, out_ckpt_valid;
  logic [CW-1:0] out_ckpt_id;
  logic          wb_valid, commit_valid, br_resolve_valid, recover_valid;
  logic [PW-1:0] wb_preg, commit_old_prd;
  logic [CW-1:0] recover_id;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rename_unit_ckpt dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_uses_rs(in_uses_rs), .in_uses_rt(in_uses_rt), .in_uses_rw(in_uses_rw),
    .in_rs(in_rs), .in_rt(in_rt), .in_rw(in_rw), .in_is_branch(in_is_branch),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_prs(out_prs), .out_prt(out_prt), .out_prd(out_prd), .out_old_prd(out_old_prd),
    .out_rs_rdy(out_rs_rdy), .out_rt_rdy(out_rt_rdy),
    .out_ckpt_valid(out_ckpt_valid), .out_ckpt_id(out_ckpt_id),
    .wb_valid(wb_valid), .wb_preg(wb_preg),
    .commit_valid(commit_valid), .commit_old_prd(commit_old_prd),
    .br_resolve_valid(br_resolve_valid),
    .recover_valid(recover_valid), .recover_id(recover_id)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 0; in_uses_rs = 0; in_uses_rt = 0; in_uses_rw = 0; in_is_branch = 0;
    in_rs = '0; in_rt = '0; in_rw = '0;
    out_ready = 1; wb_valid = 0; wb_preg = '0; commit_valid = 0; commit_old_prd = '0;
    br_resolve_valid = 0; recover_valid = 0; recover_id = '0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 0;
    #1;
    check("rst_out_valid", out_valid, 0);
    step();
    rst_n = 1;
    step();
  endtask

  task automatic set_instr(input logic urs, input int rs, input logic urt, input int rt,
                           input logic urw, input int rw, input logic br);
    in_valid = 1; in_uses_rs = urs; in_uses_rt = urt; in_uses_rw = urw;
    in_rs = AW'(rs); in_rt = AW'(rt); in_rw = AW'(rw); in_is_branch = br;
  endtask

  // Present one instruction, require it to be accepted, and clock it in.
  task automatic issue(input string tag, input logic urs, input int rs, input logic urt, input int rt,
                       input logic urw, input int rw, input logic br);
    set_instr(urs, rs, urt, rt, urw, rw, br);
    #1;
    check({tag, "_in_ready"}, in_ready, 1);
    step();
    in_valid = 0; in_is_branch = 0; wb_valid = 0;
  endtask

  initial begin
    idle();
    do_reset();
    check("rst_out_prd", out_prd, 0);
    check("rst_out_prs", out_prs, 0);
    check("rst_ckpt_valid", out_ckpt_valid, 0);
    check("rst_in_ready", in_ready, 1);

    // Basic rename and RAW dependency
    issue("a1", 1, 5, 1, 0, 1, 5, 0);
    check("a1_valid", out_valid, 1);
    check("a1_prd", out_prd, 32);
    check("a1_prs", out_prs, 5);
    check("a1_old", out_old_prd, 5);
    check("a1_rs_rdy", out_rs_rdy, 1);
    check("a1_prt", out_prt, 0);
    issue("a2", 1, 5, 0, 0, 1, 5, 0);
    check("a2_prs", out_prs, 32);
    check("a2_rs_rdy", out_rs_rdy, 0);
    check("a2_prd", out_prd, 33);
    check("a2_old", out_old_prd, 32);

    // Writeback bypass on the source being renamed, then busy cleared
    wb_valid = 1; wb_preg = 6'd33;
    issue("b1", 1, 5, 0, 0, 1, 6, 0);
    check("b1_rs_rdy_bypass", out_rs_rdy, 1);
    check("b1_prd", out_prd, 34);
    issue("b2", 1, 5, 0, 0, 0, 0, 0);
    check("b2_rs_rdy", out_rs_rdy, 1);
    check("b2_prd_none", out_prd, 0);
    in_valid = 0;
    step();
    check("b_out_valid_drops", out_valid, 0);

    // Free list exhaustion and commit refill
    do_reset();
    for (int i = 0; i < 32; i++) begin
      issue("c_alloc", 0, 0, 0, 0, 1, (i % 31) + 1, 0);
      check("c_alloc_prd", out_prd, 32 + i);
    end
    set_instr(0, 0, 0, 0, 1, 1, 0);
    #1;
    check("c_empty_stall", in_ready, 0);
    in_uses_rw = 0;
    #1;
    check("c_no_dst_ok", in_ready, 1);
    in_uses_rw = 1;
    commit_valid = 1; commit_old_prd = '0;
    step();
    check("c_commit0_ignored", in_ready, 0);
    commit_old_prd = 6'd7;
    #1;
    check("c_same_cycle_free", in_ready, 0);
    step();
    commit_valid = 0;
    issue("c_refill", 0, 0, 0, 0, 1, 2, 0);
    check("c_refill_prd", out_prd, 7);
    check("c_refill_old", out_old_prd, 33);

    // Checkpoint and mispredict recovery
    do_reset();
    issue("d_br", 0, 0, 0, 0, 1, 3, 1);
    check("d_br_prd", out_prd, 32);
    check("d_br_ckv", out_ckpt_valid, 1);
    check("d_br_ckid", out_ckpt_id, 0);
    issue("d_i1", 0, 0, 0, 0, 1, 3, 0);
    check("d_i1_prd", out_prd, 33);
    check("d_i1_ckv", out_ckpt_valid, 0);
    issue("d_i2", 0, 0, 0, 0, 1, 4, 0);
    check("d_i2_prd", out_prd, 34);
    set_instr(0, 0, 0, 0, 1, 9, 0);
    recover_valid = 1; recover_id = '0;
    #1;
    check("d_rec_blocks", in_ready, 0);
    step();
    recover_valid = 0;
    check("d_rec_clears_out", out_valid, 0);
    issue("d_post", 1, 3, 1, 4, 1, 7, 0);
    check("d_post_prs", out_prs, 32);
    check("d_post_prt", out_prt, 4);
    check("d_post_prd", out_prd, 33);
    check("d_post_old", out_old_prd, 7);
    check("d_post_rs_rdy", out_rs_rdy, 0);
    check("d_post_rt_rdy", out_rt_rdy, 1);
    issue("d_br2", 0, 0, 0, 0, 0, 0, 1);
    check("d_br2_ckid", out_ckpt_id, 0);

    // Checkpoint FIFO full, resolve, wrap; stray resolve on empty FIFO
    do_reset();
    br_resolve_valid = 1;
    step();
    br_resolve_valid = 0;
    for (int i = 0; i < 4; i++) begin
      issue("e_br", 0, 0, 0, 0, 0, 0, 1);
      check("e_br_id", out_ckpt_id, i);
    end
    set_instr(0, 0, 0, 0, 0, 0, 1);
    br_resolve_valid = 1;
    #1;
    check("e_full_stall", in_ready, 0);
    step();
    br_resolve_valid = 0;
    issue("e_br5", 0, 0, 0, 0, 0, 0, 1);
    check("e_br5_id", out_ckpt_id, 0);
    check("e_br5_valid", out_valid, 1);

    // Downstream backpressure holds the output and the free list
    do_reset();
    issue("f_a", 0, 0, 0, 0, 1, 9, 0);
    check("f_a_prd", out_prd, 32);
    out_ready = 0;
    set_instr(0, 0, 0, 0, 1, 10, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("f_hold_in_ready", in_ready, 0);
      check("f_hold_valid", out_valid, 1);
      check("f_hold_prd", out_prd, 32);
      step();
    end
    out_ready = 1;
    issue("f_b", 0, 0, 0, 0, 1, 10, 0);
    check("f_b_prd", out_prd, 33);
    issue("f_rw0", 0, 0, 0, 0, 1, 0, 0);
    check("f_rw0_prd", out_prd, 0);
    check("f_rw0_old", out_old_prd, 0);
    issue("f_c", 0, 0, 0, 0, 1, 11, 0);
    check("f_c_prd", out_prd, 34);
    check("f_c_old", out_old_prd, 11);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
